// File: rtl/logicnet_lut_layer_pkg.sv
// logicnet_pkg: shared state encoding and width/slice helpers for the LUT layer
package logicnet_pkg;
   typedef enum logic [1:0] {CFG, RUN, DRAIN} state_e;
   function automatic int nw_of(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
   function automatic int slice_lo(input int idx, input int width);
      return idx * width;
   endfunction
endpackage

// File: rtl/logicnet_lut_layer_if.sv
// logicnet_lut_layer_if: configuration, input and output handshake bundle of the LUT layer
interface logicnet_lut_layer_if #(
   parameter int IN_BITS  = 6,
   parameter int OUT_BITS = 1,
   parameter int NEURONS  = 4
);
   import logicnet_pkg::*;
   localparam int NW = nw_of(NEURONS);
   logic                         cfg_valid;
   logic                         cfg_ready;
   logic [NW-1:0]                cfg_neuron;
   logic [IN_BITS-1:0]           cfg_addr;
   logic [OUT_BITS-1:0]          cfg_data;
   logic                         cfg_last;
   logic                         cfg_mode;
   logic                         in_valid;
   logic                         in_ready;
   logic [NEURONS*IN_BITS-1:0]   in_data;
   logic                         out_valid;
   logic                         out_ready;
   logic [NEURONS*OUT_BITS-1:0]  out_data;
   modport master (
      output cfg_valid, cfg_neuron, cfg_addr, cfg_data, cfg_last, in_valid, in_data, out_ready,
      input  cfg_ready, cfg_mode, in_ready, out_valid, out_data
   );
   modport slave (
      input  cfg_valid, cfg_neuron, cfg_addr, cfg_data, cfg_last, in_valid, in_data, out_ready,
      output cfg_ready, cfg_mode, in_ready, out_valid, out_data
   );
endinterface

// File: rtl/logicnet_lut_layer_lut_table_bank.sv
// lut_table_bank: one neuron's truth table, synchronous write, combinational read
module lut_table_bank #(
   parameter int IN_BITS  = 6,
   parameter int OUT_BITS = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                we,
   input  logic [IN_BITS-1:0]  waddr,
   input  logic [OUT_BITS-1:0] wdata,
   input  logic [IN_BITS-1:0]  raddr,
   output logic [OUT_BITS-1:0] rdata
);
   localparam int DEPTH = 2 ** IN_BITS;
   (* rom_style = "distributed" *) logic [OUT_BITS-1:0] mem_q [DEPTH];
   logic [OUT_BITS-1:0] mem_d [DEPTH];
   // next table contents: a single entry replaced by an accepted write
   always_comb begin
      mem_d = mem_q;
      if (we) mem_d[waddr] = wdata;
   end
   // table flops, zeroed by reset
   always_ff @(posedge clk) begin
      if (rst) mem_q <= '{default: '0};
      else     mem_q <= mem_d;
   end
   assign rdata = mem_q[raddr];
endmodule

// File: rtl/logicnet_lut_layer.sv
// logicnet_lut_layer: runtime-loadable layer of truth-table neurons with a registered output stage
module logicnet_lut_layer
   import logicnet_pkg::*;
#(
   parameter int IN_BITS  = 6,
   parameter int OUT_BITS = 1,
   parameter int NEURONS  = 4
) (
   input logic                clk,
   input logic                rst,
   logicnet_lut_layer_if.slave bus
);
   localparam int NW = nw_of(NEURONS);
   state_e                      state_q, state_d;
   logic                        out_valid_q, out_valid_d;
   logic [NEURONS*OUT_BITS-1:0] out_data_q, out_data_d, lookup;
   logic                        out_free, cfg_acc, in_acc;
   assign out_free      = !out_valid_q || bus.out_ready;
   assign bus.cfg_ready = state_q == CFG;
   assign bus.cfg_mode  = state_q == CFG;
   assign bus.in_ready  = state_q == RUN && !bus.cfg_valid && out_free;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign cfg_acc       = bus.cfg_valid && bus.cfg_ready;
   assign in_acc        = bus.in_valid && bus.in_ready;
   for (genvar n = 0; n < NEURONS; n++) begin : g_neuron
      lut_table_bank #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) u_bank (
         .clk   (clk),
         .rst   (rst),
         .we    (cfg_acc && bus.cfg_neuron == NW'(n)),
         .waddr (bus.cfg_addr),
         .wdata (bus.cfg_data),
         .raddr (bus.in_data[slice_lo(n, IN_BITS) +: IN_BITS]),
         .rdata (lookup[slice_lo(n, OUT_BITS) +: OUT_BITS])
      );
   end
   // mode sequencing and output-register update; out-of-range neuron writes simply match no bank
   always_comb begin
      state_d     = (state_q == CFG) ? ((cfg_acc && bus.cfg_last) ? RUN : CFG) :
                    (state_q == RUN) ? (bus.cfg_valid ? DRAIN : RUN) :
                    (out_free ? CFG : DRAIN);
      out_valid_d = in_acc || (out_valid_q && !bus.out_ready);
      out_data_d  = in_acc ? lookup : out_data_q;
   end
   // state and output register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= CFG;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end
endmodule

// File: tb/tb_logicnet_lut_layer.sv
// tb_logicnet_lut_layer: randomized checks of the LUT layer against a table-lookup model
module tb_logicnet_lut_layer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;
   bit   tbl [4][64];
   always #5 clk = ~clk;
   logicnet_lut_layer_if #(.IN_BITS(6), .OUT_BITS(1), .NEURONS(4)) b4 ();
   logicnet_lut_layer_if #(.IN_BITS(6), .OUT_BITS(1), .NEURONS(3)) b3 ();
   logicnet_lut_layer #(.IN_BITS(6), .OUT_BITS(1), .NEURONS(4)) dut  (.clk(clk), .rst(rst), .bus(b4));
   logicnet_lut_layer #(.IN_BITS(6), .OUT_BITS(1), .NEURONS(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));

   function automatic logic [3:0] model(input logic [23:0] d);
      logic [3:0] r;
      for (int n = 0; n < 4; n++) r[n] = tbl[n][d[n*6 +: 6]];
      return r;
   endfunction

   task automatic clear_model();
      for (int n = 0; n < 4; n++) for (int a = 0; a < 64; a++) tbl[n][a] = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      b4.cfg_valid = 0; b4.cfg_neuron = '0; b4.cfg_addr = '0; b4.cfg_data = '0; b4.cfg_last = 0;
      b4.in_valid = 0; b4.in_data = '0; b4.out_ready = 1;
      b3.cfg_valid = 0; b3.cfg_neuron = '0; b3.cfg_addr = '0; b3.cfg_data = '0; b3.cfg_last = 0;
      b3.in_valid = 0; b3.in_data = '0; b3.out_ready = 1;
   endtask

   task automatic cfg_write4(input int nr, input int a, input bit dv, input bit last);
      int t = 0;
      b4.out_ready = 1;
      b4.cfg_valid = 1; b4.cfg_neuron = 2'(nr); b4.cfg_addr = 6'(a); b4.cfg_data = dv; b4.cfg_last = last;
      @(negedge clk);
      while (!b4.cfg_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (b4.cfg_ready !== 1'b1) begin
         errors++;
         $display("FAIL cfg_write_wait: cfg_ready=%b required 1", b4.cfg_ready);
      end else tbl[nr][a] = dv;
      step();
      b4.cfg_valid = 0; b4.cfg_last = 0;
   endtask

   task automatic send4(input logic [23:0] d);
      int t = 0;
      b4.in_valid = 1; b4.in_data = d;
      @(negedge clk);
      while (!b4.in_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (b4.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL send_wait: in_ready=%b required 1", b4.in_ready);
      end
      step();
      b4.in_valid = 0;
   endtask

   task automatic test_reset();
      checks += 6;
      if (b4.cfg_mode !== 1'b1) begin errors++; $display("FAIL reset_cfg_mode: got %b want 1", b4.cfg_mode); end
      if (b4.cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready: got %b want 1", b4.cfg_ready); end
      if (b4.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", b4.in_ready); end
      if (b4.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", b4.out_valid); end
      if (b4.out_data !== 4'h0) begin errors++; $display("FAIL reset_out_data: got %h want 0", b4.out_data); end
      if (b3.cfg_mode !== 1'b1) begin errors++; $display("FAIL reset_cfg_mode3: got %b want 1", b3.cfg_mode); end
   endtask

   task automatic test_load();
      cfg_write4(0, 'h29, 1, 0);
      checks++;
      if (b4.cfg_mode !== 1'b1) begin errors++; $display("FAIL load_mode_mid: got %b want 1", b4.cfg_mode); end
      cfg_write4(3, 'h0D, 1, 1);
      checks++;
      if (b4.cfg_mode !== 1'b0) begin errors++; $display("FAIL load_mode_fall: got %b want 0", b4.cfg_mode); end
      send4({6'h0D, 6'h00, 6'h00, 6'h29});
      checks += 2;
      if (b4.out_valid !== 1'b1) begin errors++; $display("FAIL load_out_valid: got %b want 1", b4.out_valid); end
      if (b4.out_data !== 4'b1001) begin errors++; $display("FAIL load_out_data: got %b want 1001", b4.out_data); end
      send4({6'h0C, 6'h29, 6'h0D, 6'h28});
      checks++;
      if (b4.out_data !== 4'b0000) begin errors++; $display("FAIL load_other_addr: got %b want 0000", b4.out_data); end
      step();
   endtask

   task automatic test_stream();
      logic [23:0] d;
      logic [3:0]  prev = '0;
      int          beats = 0;
      b4.out_ready = 1;
      for (int i = 0; i <= 64; i++) begin
         if (i < 64) begin
            d = {18'($urandom), 6'(i)};
            b4.in_valid = 1; b4.in_data = d;
         end else b4.in_valid = 0;
         @(negedge clk);
         if (i > 0) begin
            checks++;
            if (b4.out_valid !== 1'b1 || b4.out_data !== prev || b4.out_data[0] !== (i - 1 == 'h29)) begin
               errors++;
               $display("FAIL stream_beat %0d: valid=%b data=%b want valid=1 data=%b", i - 1, b4.out_valid, b4.out_data, prev);
            end
            if (b4.out_valid === 1'b1) beats++;
         end
         if (i < 64) begin
            checks++;
            if (b4.in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready %0d: got %b want 1", i, b4.in_ready); end
         end
         prev = model(d);
         step();
      end
      checks++;
      if (beats != 64) begin errors++; $display("FAIL stream_beats: got %0d want 64", beats); end
   endtask

   task automatic test_backpressure();
      logic [23:0] d1 = 24'($urandom);
      logic [23:0] d2 = 24'($urandom);
      logic [3:0]  e1;
      b4.out_ready = 0;
      send4(d1);
      e1 = model(d1);
      b4.in_valid = 1; b4.in_data = d2;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (b4.out_valid !== 1'b1 || b4.out_data !== e1 || b4.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold %0d: valid=%b data=%b in_ready=%b want 1 %b 0", i, b4.out_valid, b4.out_data, b4.in_ready, e1);
         end
         step();
      end
      b4.out_ready = 1;
      @(negedge clk);
      checks++;
      if (b4.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", b4.in_ready); end
      step();
      b4.in_valid = 0;
      checks++;
      if (b4.out_valid !== 1'b1 || b4.out_data !== model(d2)) begin
         errors++;
         $display("FAIL bp_next_beat: valid=%b data=%b want 1 %b", b4.out_valid, b4.out_data, model(d2));
      end
      step();
   endtask

   task automatic test_reconfig();
      logic [23:0] d = {18'($urandom), 6'h29};
      logic [3:0]  e;
      b4.out_ready = 0;
      send4(d);
      e = model(d);
      b4.cfg_valid = 1; b4.cfg_neuron = 2'd0; b4.cfg_addr = 6'h29; b4.cfg_data = 1'b0; b4.cfg_last = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (b4.cfg_ready !== 1'b0 || b4.in_ready !== 1'b0 || b4.cfg_mode !== 1'b0 || b4.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL drain_hold %0d: cfg_ready=%b in_ready=%b cfg_mode=%b out_valid=%b want 0 0 0 1",
                     i, b4.cfg_ready, b4.in_ready, b4.cfg_mode, b4.out_valid);
         end
         step();
      end
      b4.out_ready = 1;
      @(negedge clk);
      checks++;
      if (b4.out_data !== e || e[0] !== 1'b1) begin errors++; $display("FAIL drain_beat: got %b want %b", b4.out_data, e); end
      step();
      checks++;
      if (b4.cfg_mode !== 1'b1 || b4.cfg_ready !== 1'b1) begin
         errors++;
         $display("FAIL drain_to_cfg: cfg_mode=%b cfg_ready=%b want 1 1", b4.cfg_mode, b4.cfg_ready);
      end
      step();
      tbl[0]['h29] = 1'b0;
      b4.cfg_valid = 0; b4.cfg_last = 0;
      checks++;
      if (b4.cfg_mode !== 1'b0) begin errors++; $display("FAIL reconfig_run: cfg_mode=%b want 0", b4.cfg_mode); end
      send4(d);
      checks++;
      if (b4.out_data !== model(d) || b4.out_data[0] !== 1'b0) begin
         errors++;
         $display("FAIL reconfig_overwrite: got %b want %b", b4.out_data, model(d));
      end
      step();
   endtask

   task automatic test_random(input int writes, input int cycles);
      logic [3:0] q[$];
      bit         fire, acc;
      for (int i = 0; i < writes; i++)
         cfg_write4(int'($urandom_range(0, 3)), int'($urandom_range(0, 63)), 1'($urandom), i == writes - 1);
      for (int c = 0; c < cycles; c++) begin
         b4.in_valid = $urandom_range(0, 3) != 0;
         b4.in_data = 24'($urandom);
         b4.out_ready = $urandom_range(0, 3) != 0;
         @(negedge clk);
         checks += 2;
         if (b4.out_valid !== (q.size() != 0)) begin
            errors++;
            $display("FAIL rand_out_valid c%0d: got %b want %b", c, b4.out_valid, q.size() != 0);
         end
         if (b4.in_ready !== (q.size() == 0 || b4.out_ready)) begin
            errors++;
            $display("FAIL rand_in_ready c%0d: got %b want %b", c, b4.in_ready, q.size() == 0 || b4.out_ready);
         end
         if (q.size() != 0) begin
            checks++;
            if (b4.out_data !== q[0]) begin errors++; $display("FAIL rand_out_data c%0d: got %b want %b", c, b4.out_data, q[0]); end
         end
         fire = b4.out_valid && b4.out_ready;
         acc = b4.in_valid && b4.in_ready;
         step();
         if (fire && q.size() != 0) void'(q.pop_front());
         if (acc) q.push_back(model(b4.in_data));
      end
      b4.in_valid = 0; b4.out_ready = 1;
      step();
   endtask

   task automatic test_out_of_range();
      int addrs [3] = '{5, 'h29, 'h3F};
      int t;
      for (int i = 0; i < 3; i++) begin
         t = 0;
         b3.cfg_valid = 1; b3.cfg_neuron = 2'd3; b3.cfg_addr = 6'(addrs[i]); b3.cfg_data = 1'b1; b3.cfg_last = i == 2;
         @(negedge clk);
         while (!b3.cfg_ready && t < 20) begin @(negedge clk); t++; end
         checks++;
         if (b3.cfg_ready !== 1'b1) begin errors++; $display("FAIL oor_accept %0d: cfg_ready=%b want 1", i, b3.cfg_ready); end
         step();
      end
      b3.cfg_valid = 0; b3.cfg_last = 0;
      checks++;
      if (b3.cfg_mode !== 1'b0) begin errors++; $display("FAIL oor_last: cfg_mode=%b want 0", b3.cfg_mode); end
      for (int i = 0; i < 3; i++) begin
         b3.in_valid = 1; b3.in_data = {3{6'(addrs[i])}}; b3.out_ready = 1;
         step();
         checks++;
         if (b3.out_valid !== 1'b1 || b3.out_data !== 3'b000) begin
            errors++;
            $display("FAIL oor_output %0d: valid=%b data=%b want 1 000", i, b3.out_valid, b3.out_data);
         end
      end
      b3.in_valid = 0;
      step();
   endtask

   task automatic test_reset_mid();
      cfg_write4(0, 'h29, 1, 0);
      cfg_write4(2, 'h22, 1, 0);
      rst = 1;
      step();
      rst = 0;
      clear_model();
      checks++;
      if (b4.out_valid !== 1'b0 || b4.cfg_mode !== 1'b1 || b4.cfg_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_load: out_valid=%b cfg_mode=%b cfg_ready=%b want 0 1 1", b4.out_valid, b4.cfg_mode, b4.cfg_ready);
      end
      cfg_write4(1, 'h07, 1, 0);
      cfg_write4(3, 'h30, 1, 1);
      b4.out_ready = 0;
      send4({6'h30, 6'h00, 6'h07, 6'h00});
      checks++;
      if (b4.out_valid !== 1'b1 || b4.out_data !== 4'b1010) begin
         errors++;
         $display("FAIL rst_prestream: valid=%b data=%b want 1 1010", b4.out_valid, b4.out_data);
      end
      rst = 1;
      step();
      rst = 0;
      clear_model();
      checks++;
      if (b4.out_valid !== 1'b0 || b4.cfg_mode !== 1'b1 || b4.out_data !== 4'h0) begin
         errors++;
         $display("FAIL rst_stream: out_valid=%b cfg_mode=%b data=%b want 0 1 0000", b4.out_valid, b4.cfg_mode, b4.out_data);
      end
      cfg_write4(0, 0, 0, 1);
      b4.out_ready = 1;
      send4({6'h30, 6'h22, 6'h07, 6'h29});
      checks++;
      if (b4.out_valid !== 1'b1 || b4.out_data !== 4'b0000) begin
         errors++;
         $display("FAIL rst_tables_zero: valid=%b data=%b want 1 0000", b4.out_valid, b4.out_data);
      end
      step();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      idle();
      clear_model();
      repeat (2) @(posedge clk);
      #1;
      rst = 0;
      test_reset();
      test_load();
      test_stream();
      test_backpressure();
      test_reconfig();
      test_random(40, 300);
      test_random(10, 200);
      test_out_of_range();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
